// File: rtl/div_share_ctrl.sv
// Purpose : round-robin sharing of one iterative divider among NREQ requesters.
// Latency : gnt->resp_valid is 1 cycle for illegal operands, 2 + WAIT cycles otherwise.
// Backpr. : one job in flight; other requesters hold req until their gnt pulse.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   req                 per-requester request level, held until gnt
//   dividend_in/divisor_in/m_in/n_in  packed per-requester operands (slot i at i*width)
//   gnt                 one-hot accept pulse; operands are sampled in that cycle
//   resp_valid          one-hot result strobe to the winner
//   resp_quotient/rem   result, held between strobes
//   resp_err            with resp_valid: illegal operands or timeout (result forced to 0)
//   div_start, div_*    start pulse and latched operands to the shared divider
//   div_quotient/rem/done  divider result and completion flag
//   busy                high whenever a job is in progress
module div_share_ctrl #(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 40
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req,
   input  logic [32*NREQ-1:0]   dividend_in,
   input  logic [32*NREQ-1:0]   divisor_in,
   input  logic [5*NREQ-1:0]    m_in,
   input  logic [5*NREQ-1:0]    n_in,
   output logic [NREQ-1:0]      gnt,
   output logic [NREQ-1:0]      resp_valid,
   output logic [31:0]          resp_quotient,
   output logic [31:0]          resp_rem,
   output logic                 resp_err,
   output logic                 div_start,
   output logic [31:0]          div_dividend,
   output logic [31:0]          div_divisor,
   output logic [4:0]           div_m,
   output logic [4:0]           div_n,
   input  logic [31:0]          div_quotient,
   input  logic [31:0]          div_rem,
   input  logic                 div_done,
   output logic                 busy
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t          state, state_nx;
   logic [IW-1:0]   rr_ptr;
   logic [IW-1:0]   win;
   logic [IW-1:0]   pick;
   logic [IW-1:0]   cand;
   logic            pick_vld;
   logic            illegal;
   logic            done_ok;
   logic            tmo;
   logic [5:0]      wcnt;
   logic            err_q;

   logic [31:0]     dd_arr [NREQ];
   logic [31:0]     dv_arr [NREQ];
   logic [4:0]      m_arr  [NREQ];
   logic [4:0]      n_arr  [NREQ];

   // Unpack the flat operand buses so the winner can be selected by index.
   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign dd_arr[g] = dividend_in[32*g +: 32];
      assign dv_arr[g] = divisor_in[32*g +: 32];
      assign m_arr[g]  = m_in[5*g +: 5];
      assign n_arr[g]  = n_in[5*g +: 5];
   end

   // Round-robin pick: scanning offsets from high to low lets the smallest
   // offset from rr_ptr overwrite the others, so the first requester at or
   // after the pointer wins.
   always_comb begin
      pick     = '0;
      cand     = '0;
      pick_vld = 1'b0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         cand = IW'((int'(rr_ptr) + k) % NREQ);
         if (req[cand]) begin
            pick     = cand;
            pick_vld = 1'b1;
         end
      end
   end

   // Operands the divider cannot handle are answered directly with an error.
   assign illegal = (dv_arr[pick] == 32'd0) || (m_arr[pick] < n_arr[pick]);

   // The done flag seen in the first WAIT cycle belongs to the previous job.
   assign done_ok = (wcnt != 6'd0) && div_done;
   assign tmo     = (wcnt == 6'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      gnt        = '0;
      resp_valid = '0;
      resp_err   = 1'b0;
      div_start  = 1'b0;
      busy       = 1'b1;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (pick_vld) begin
               gnt      = NREQ'(1) << pick;
               state_nx = illegal ? RESP : ISSUE;
            end
         end
         ISSUE: begin
            div_start = 1'b1;
            state_nx  = WAIT;
         end
         WAIT: begin
            if (done_ok || tmo) begin
               state_nx = RESP;
            end
         end
         RESP: begin
            resp_valid = NREQ'(1) << win;
            resp_err   = err_q;
            state_nx   = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_ptr        <= '0;
         win           <= '0;
         wcnt          <= '0;
         err_q         <= 1'b0;
         resp_quotient <= '0;
         resp_rem      <= '0;
         div_dividend  <= '0;
         div_divisor   <= '0;
         div_m         <= '0;
         div_n         <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_vld) begin
                  win          <= pick;
                  rr_ptr       <= (pick == IW'(NREQ - 1)) ? '0 : pick + 1'b1;
                  div_dividend <= dd_arr[pick];
                  div_divisor  <= dv_arr[pick];
                  div_m        <= m_arr[pick];
                  div_n        <= n_arr[pick];
                  err_q        <= illegal;
                  if (illegal) begin
                     resp_quotient <= '0;
                     resp_rem      <= '0;
                  end
               end
            end
            ISSUE: begin
               wcnt <= '0;
            end
            WAIT: begin
               wcnt <= wcnt + 6'd1;
               if (done_ok) begin
                  resp_quotient <= div_quotient;
                  resp_rem      <= div_rem;
                  err_q         <= 1'b0;
               end else if (tmo) begin
                  resp_quotient <= '0;
                  resp_rem      <= '0;
                  err_q         <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_share_ctrl.sv
// Purpose : self-checking bench for div_share_ctrl with a behavioural divider.
// Latency : a per-cycle model predicts every output from elapsed cycles since grant.
// Backpr. : requesters hold req until granted, then drop it.
module tb_div_share_ctrl;

   localparam int NREQ    = 4;
   localparam int TIMEOUT = 40;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic [NREQ-1:0]      req = '0;
   logic [32*NREQ-1:0]   dividend_in = '0;
   logic [32*NREQ-1:0]   divisor_in = '0;
   logic [5*NREQ-1:0]    m_in = '0;
   logic [5*NREQ-1:0]    n_in = '0;
   logic [NREQ-1:0]      gnt;
   logic [NREQ-1:0]      resp_valid;
   logic [31:0]          resp_quotient;
   logic [31:0]          resp_rem;
   logic                 resp_err;
   logic                 div_start;
   logic [31:0]          div_dividend;
   logic [31:0]          div_divisor;
   logic [4:0]           div_m;
   logic [4:0]           div_n;
   logic [31:0]          div_quotient;
   logic [31:0]          div_rem;
   logic                 div_done;
   logic                 busy;

   div_share_ctrl #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .req(req),
      .dividend_in(dividend_in), .divisor_in(divisor_in), .m_in(m_in), .n_in(n_in),
      .gnt(gnt), .resp_valid(resp_valid), .resp_quotient(resp_quotient),
      .resp_rem(resp_rem), .resp_err(resp_err), .div_start(div_start),
      .div_dividend(div_dividend), .div_divisor(div_divisor), .div_m(div_m), .div_n(div_n),
      .div_quotient(div_quotient), .div_rem(div_rem), .div_done(div_done), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic to_fail(input string nm);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: timed out waiting for the DUT (cycle %0d)", nm, cyc);
   endtask

   // ---------------- divider model ----------------
   // dmode 0: done rises dlat cycles after start and stays high (stale later)
   // dmode 1: never done; dmode 2: done permanently high
   int          dmode = 0;
   int          dlat = 3;
   logic        done_r = 1'b0;
   logic        drun = 1'b0;
   int          dcnt = 0;
   logic [31:0] dq = '0;
   logic [31:0] dr = '0;

   always @(posedge clk) begin
      if (div_start) begin
         dq     <= (div_divisor != 0) ? div_dividend / div_divisor : 32'd0;
         dr     <= (div_divisor != 0) ? div_dividend % div_divisor : 32'd0;
         done_r <= 1'b0;
         drun   <= 1'b1;
         dcnt   <= 1;
      end else if (drun) begin
         if (dcnt + 1 >= dlat) begin
            done_r <= 1'b1;
            drun   <= 1'b0;
         end
         dcnt <= dcnt + 1;
      end
   end

   assign div_quotient = dq;
   assign div_rem      = dr;
   assign div_done     = (dmode == 2) ? 1'b1 : (dmode == 1) ? 1'b0 : done_r;

   // ---------------- reference model ----------------
   function automatic int pick_rr(input logic [NREQ-1:0] r, input int p);
      for (int k = 0; k < NREQ; k++) begin
         if (r[(p + k) % NREQ]) return (p + k) % NREQ;
      end
      return -1;
   endfunction

   function automatic logic [NREQ-1:0] oh(input int i);
      return NREQ'(1) << i;
   endfunction

   // Job described by elapsed cycles since its grant (grant cycle = 0).
   bit          m_known = 0;
   bit          m_busy = 0;
   int          m_ptr = 0;
   int          m_win = 0;
   int          m_t = 0;
   int          m_resp_at = -1;
   bit          m_legal = 0;
   logic [31:0] m_jq = '0, m_jr = '0;
   logic        m_jerr = 1'b0;
   logic [31:0] m_rq = '0, m_rr = '0;
   logic [31:0] m_dd = '0, m_dv = '0;
   logic [4:0]  m_m = '0, m_n = '0;

   logic [NREQ-1:0] e_gnt, e_rv;
   logic            e_start, e_busy, e_err;
   logic [31:0]     e_q, e_r;
   int              mw, wn;

   // observed event log for hand-computed checks
   int          g_tot = 0, r_tot = 0, s_tot = 0;
   int          g_log [64];
   int          r_log [64];
   int          g_cyc = 0, r_cyc = 0, s_cyc = 0;
   logic [31:0] r_q = '0, r_r = '0;
   logic        r_err = 1'b0;

   always @(negedge clk) begin
      e_gnt   = '0;
      e_rv    = '0;
      e_start = 1'b0;
      e_busy  = m_busy;
      e_err   = 1'b0;
      e_q     = m_rq;
      e_r     = m_rr;
      if (!m_busy) begin
         mw = pick_rr(req, m_ptr);
         if (mw >= 0) e_gnt = oh(mw);
      end else begin
         e_start = m_legal && (m_t == 1);
         if (m_t == m_resp_at) begin
            e_rv  = oh(m_win);
            e_err = m_jerr;
            e_q   = m_jq;
            e_r   = m_jr;
         end
      end

      if (m_known) begin
         chk("gnt", gnt, e_gnt);
         chk("resp_valid", resp_valid, e_rv);
         chk("div_start", div_start, e_start);
         chk("busy", busy, e_busy);
         chk("resp_err", resp_err, e_err);
         chk("resp_quotient", resp_quotient, e_q);
         chk("resp_rem", resp_rem, e_r);
         chk("div_dividend", div_dividend, m_dd);
         chk("div_divisor", div_divisor, m_dv);
         chk("div_m", div_m, m_m);
         chk("div_n", div_n, m_n);
      end

      if (rst_n) begin
         for (int k = 0; k < NREQ; k++) begin
            if (gnt[k]) begin
               g_log[g_tot % 64] = k;
               g_tot++;
               g_cyc = cyc;
            end
            if (resp_valid[k]) begin
               r_log[r_tot % 64] = k;
               r_tot++;
               r_cyc = cyc;
               r_q   = resp_quotient;
               r_r   = resp_rem;
               r_err = resp_err;
            end
         end
         if (div_start) begin
            s_tot++;
            s_cyc = cyc;
         end
      end

      // advance the model across the coming rising edge
      if (!rst_n) begin
         m_known = 1;
         m_busy  = 0;
         m_ptr   = 0;
         m_rq = '0; m_rr = '0;
         m_dd = '0; m_dv = '0; m_m = '0; m_n = '0;
      end else if (!m_busy) begin
         mw = pick_rr(req, m_ptr);
         if (mw >= 0) begin
            m_busy  = 1;
            m_t     = 1;
            m_win   = mw;
            m_ptr   = (mw + 1) % NREQ;
            m_dd    = dividend_in[32*mw +: 32];
            m_dv    = divisor_in[32*mw +: 32];
            m_m     = m_in[5*mw +: 5];
            m_n     = n_in[5*mw +: 5];
            m_legal = !((m_dv == 0) || (m_m < m_n));
            if (!m_legal) begin
               m_resp_at = 1;
               m_jq = '0; m_jr = '0; m_jerr = 1'b1;
            end else begin
               m_resp_at = -1;
            end
         end
      end else if (m_t == m_resp_at) begin
         m_busy = 0;
         m_rq   = m_jq;
         m_rr   = m_jr;
      end else begin
         // cycles at m_t >= 2 are divider wait cycles, numbered wn from 1
         wn = m_t - 1;
         if (m_resp_at < 0 && m_t >= 2) begin
            if (wn >= 2 && div_done) begin
               m_resp_at = m_t + 1;
               m_jq = div_quotient; m_jr = div_rem; m_jerr = 1'b0;
            end else if (wn == TIMEOUT) begin
               m_resp_at = m_t + 1;
               m_jq = '0; m_jr = '0; m_jerr = 1'b1;
            end
         end
         m_t++;
      end
   end

   // ---------------- stimulus ----------------
   int idle_cyc = 0;

   task automatic go();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int i, input logic [31:0] dd, input logic [31:0] dv,
                         input logic [4:0] m, input logic [4:0] n);
      dividend_in[32*i +: 32] = dd;
      divisor_in[32*i +: 32]  = dv;
      m_in[5*i +: 5]          = m;
      n_in[5*i +: 5]          = n;
   endtask

   task automatic wait_gnt(input string nm);
      int k;
      k = 0;
      @(negedge clk);
      while (gnt == '0 && k < 200) begin
         @(negedge clk);
         k++;
      end
      if (gnt == '0) to_fail(nm);
   endtask

   task automatic wait_idle(input string nm);
      int k;
      k = 0;
      @(negedge clk);
      while (busy && k < 200) begin
         @(negedge clk);
         k++;
      end
      if (busy) to_fail(nm);
      idle_cyc = cyc;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int g0, r0, s0;
      for (int i = 0; i < NREQ; i++) set_op(i, 32'(20 + 10*i), 32'(3 + i), 5'd8, 5'd2);
      req   = '1;
      dmode = 0;
      dlat  = 3;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // round robin with all four held from reset
      g0 = g_tot; r0 = r_tot;
      for (int k = 0; k < 5; k++) wait_gnt("rr_gnt");
      go(); req = '0;
      wait_idle("rr_idle");
      for (int k = 0; k < 5; k++) begin
         chk("rr_gnt_order", g_log[(g0 + k) % 64], k % 4);
         chk("rr_resp_order", r_log[(r0 + k) % 64], k % 4);
      end

      // single legal request: 100 / 7 = 14 rem 2, done 6 cycles after start
      go(); set_op(0, 100, 7, 7, 3); dlat = 6;
      g0 = g_tot; req = 4'b0001;
      wait_gnt("t1_gnt");
      go(); req = '0;
      wait_idle("t1_idle");
      chk("t1_gnt_count", g_tot - g0, 1);
      chk("t1_gnt_idx", g_log[g0 % 64], 0);
      chk("t1_start_lat", s_cyc - g_cyc, 1);
      chk("t1_resp_lat", r_cyc - g_cyc, 8);
      chk("t1_quotient", r_q, 14);
      chk("t1_rem", r_r, 2);
      chk("t1_err", r_err, 0);
      chk("t1_resp_idx", r_log[(r_tot - 1) % 64], 0);
      chk("t1_busy_fall", idle_cyc - r_cyc, 1);

      // illegal: divisor zero, then m < n
      for (int v = 0; v < 2; v++) begin
         go();
         if (v == 0) set_op(2, 50, 0, 6, 2);
         else        set_op(2, 50, 4, 3, 5);
         s0 = s_tot; g0 = g_tot; req = 4'b0100;
         wait_gnt("ill_gnt");
         go(); req = '0;
         wait_idle("ill_idle");
         chk("ill_gnt_idx", g_log[g0 % 64], 2);
         chk("ill_resp_lat", r_cyc - g_cyc, 1);
         chk("ill_err", r_err, 1);
         chk("ill_quotient", r_q, 0);
         chk("ill_rem", r_r, 0);
         chk("ill_no_start", s_tot - s0, 0);
         chk("ill_resp_idx", r_log[(r_tot - 1) % 64], 2);
      end

      // stale done held high: capture on the second wait cycle; 200/9 = 22 rem 2
      go(); dmode = 2; set_op(1, 200, 9, 8, 4);
      r0 = r_tot; req = 4'b0010;
      wait_gnt("stale_gnt");
      go(); req = '0;
      wait_idle("stale_idle");
      repeat (5) @(negedge clk);
      chk("stale_resp_lat", r_cyc - g_cyc, 4);
      chk("stale_quotient", r_q, 22);
      chk("stale_rem", r_r, 2);
      chk("stale_resp_count", r_tot - r0, 1);

      // timeout, then a normal job
      go(); dmode = 1; set_op(3, 77, 5, 7, 3); req = 4'b1000;
      wait_gnt("tmo_gnt");
      go(); req = '0;
      wait_idle("tmo_idle");
      chk("tmo_err", r_err, 1);
      chk("tmo_lat", r_cyc - s_cyc, TIMEOUT + 1);
      chk("tmo_quotient", r_q, 0);
      chk("tmo_resp_idx", r_log[(r_tot - 1) % 64], 3);
      go(); dmode = 0; dlat = 6; req = 4'b0001;
      wait_gnt("post_tmo_gnt");
      go(); req = '0;
      wait_idle("post_tmo_idle");
      chk("post_tmo_lat", r_cyc - g_cyc, 8);
      chk("post_tmo_quotient", r_q, 14);
      chk("post_tmo_err", r_err, 0);

      // reset during WAIT: job abandoned, pointer back to 0
      go(); dmode = 1; req = 4'b0010;
      wait_gnt("rst_gnt");
      go(); req = '0;
      repeat (3) go();
      r0 = r_tot;
      rst_n = 1'b0;
      go(); rst_n = 1'b1;
      @(negedge clk);
      chk("rst_gnt", gnt, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_err", resp_err, 0);
      chk("rst_div_start", div_start, 0);
      chk("rst_busy", busy, 0);
      chk("rst_resp_quotient", resp_quotient, 0);
      chk("rst_resp_rem", resp_rem, 0);
      chk("rst_div_dividend", div_dividend, 0);
      chk("rst_div_divisor", div_divisor, 0);
      repeat (3) @(negedge clk);
      chk("rst_no_resp", r_tot - r0, 0);
      go(); dmode = 0; dlat = 3; set_op(2, 90, 4, 7, 3);
      g0 = g_tot; req = 4'b0101;
      wait_gnt("rst_first_gnt");
      go(); req = 4'b0100;
      wait_gnt("rst_second_gnt");
      go(); req = '0;
      wait_idle("rst_idle");
      chk("rst_first_winner", g_log[g0 % 64], 0);
      chk("rst_second_winner", g_log[(g0 + 1) % 64], 2);
      chk("rst_last_quotient", r_q, 22);
      chk("rst_last_rem", r_r, 2);

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
